burst_mem_responder: RTL and testbench
======================================

// Module: burst_mem_responder
// PURPOSE
//   Target-side memory responder for the fetch/load initiators: accepts single-word and burst
//   read/write requests on the existing memory interface (address, access_size, rw, enable),
//   stores words in an internal array and returns read data one word per cycle with busy/valid flags.
//   Sits between the fetch stage (initiator) and backing storage; replaces testbench-driven loading.
// PARAMETERS
//   DATA_WIDTH   32             word width in bits
//   ADDR_WIDTH   32             byte address width
//   DEPTH        1048576        storage size in bytes (multiple of 64)
//   START_ADDR   32'h80020000   byte address mapped to array offset 0
// PORTS
//   clock        in   1    single clock, all state on rising edge
//   reset_n      in   1    asynchronous, active-low reset
//   address      in   32   byte address of first beat; bits [1:0] ignored
//   data_in      in   32   write data, sampled on every write beat
//   access_size  in   2    00=1 word, 01=4, 10=8, 11=16 words
//   rw           in   1    0=write, 1=read
//   enable       in   1    request strobe; accepted only when not busy
//   busy         out  1    burst in progress, new requests ignored
//   data_out     out  32   read data, registered
//   data_valid   out  1    data_out holds a read beat this cycle
// BEHAVIOUR
//   - Reset (async, reset_n=0): busy=0, data_out=0, data_valid=0, state=IDLE, beat counter=0.
//     Array contents are NOT reset. Reset mid-burst aborts the burst; first edge after release is IDLE.
//   - States: IDLE, BURST.
//   - IDLE & enable=1 at edge T: latch rw, word offset, beats N (1/4/8/16); beat 0 executes at T.
//     N=1 -> stay IDLE; N>1 -> BURST with beats_left=N-1, busy=1 after T.
//   - BURST: one beat per edge, offset+1 each beat; busy drops after the edge executing the last beat
//     (busy high exactly N-1 cycles). enable/address/access_size/rw ignored while busy.
//   - Write beat: mem[offset] <= data_in at that edge. data_valid=0 during writes.
//   - Read beat k (k=0..N-1): data_out <= mem[offset+k] at edge T+k; data_valid=1 for the cycle
//     after each read edge, 0 otherwise; data_out holds last value when data_valid=0.
//   - Address map: word offset = ((address - START_ADDR) mod DEPTH) >> 2; burst increments wrap
//     modulo DEPTH/4 words (last word -> word 0). No error signalling for out-of-range addresses.
//   - Read-after-write: a read accepted the edge after a write beat returns the new data.
//   - Back-to-back: enable held high in the cycle busy falls is accepted at that edge (no bubble).
// STRUCTURE
//   - Shared package mem_pkg: access_size encodings (ACC_1W..ACC_16W), beats-per-size function,
//     START_ADDR, RW_READ/RW_WRITE constants, state enum {IDLE, BURST}.
//   - One sub-module: mem_array (single-port word RAM, sync write, sync registered read).
//   - Top holds FSM, beat counter (5 bits), offset register, valid/busy logic.
// TESTING
//   1. Write 0xDEADBEEF @0x80020000 (size 00), then read -> busy never set; data_out=0xDEADBEEF,
//      data_valid=1 exactly one cycle.
//   2. Write 4-word burst 0x11,0x22,0x33,0x44 @0x80020010, read back size 01 -> busy high 3 cycles,
//      data_valid 4 consecutive cycles returning 0x11..0x44 in order.
//   3. 16-word read burst with enable pulsed and address changed mid-burst -> pulses ignored,
//      16 sequential words from original base, busy high 15 cycles.
//   4. Assert reset_n=0 during beat 3 of an 8-word read -> busy/data_valid/data_out go 0 immediately;
//      next request after release served normally; previously written words intact.
//   5. 4-word write at last word (START_ADDR+DEPTH-4) -> words 2..4 land at offsets 0..2;
//      readback at START_ADDR returns them.
//   6. Back-to-back: 4-word read then enable held for 1-word write at busy fall -> accepted with no gap.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings, address map constant and FSM states for the burst memory responder
package mem_pkg;

    localparam logic [1:0] ACC_1W  = 2'b00;
    localparam logic [1:0] ACC_4W  = 2'b01;
    localparam logic [1:0] ACC_8W  = 2'b10;
    localparam logic [1:0] ACC_16W = 2'b11;

    localparam logic [31:0] START_ADDR = 32'h8002_0000;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic {IDLE, BURST} state_t;

    function automatic logic [4:0] beats_for_size(input logic [1:0] size);
        case (size)
            ACC_1W:  return 5'd1;
            ACC_4W:  return 5'd4;
            ACC_8W:  return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port word RAM with synchronous write and registered synchronous read
module mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 262144,
    parameter int AW         = 18
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [AW-1:0]         addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is never reset; only the output register is.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// rtl/burst_mem_responder.sv - single/burst read-write memory target with busy and data_valid flags
module burst_mem_responder
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = ADDR_WIDTH'(mem_pkg::START_ADDR)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
);

    localparam int WORDS = DEPTH / 4;
    localparam int OW    = $clog2(WORDS);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_B   = ADDR_WIDTH'(DEPTH);
    localparam logic [OW-1:0]         LAST_WORD = OW'(WORDS - 1);

    state_t          state_q;
    logic [4:0]      beats_left_q;
    logic [OW-1:0]   offset_q;
    logic            rw_q;
    logic            busy_q;
    logic            valid_q;

    logic [ADDR_WIDTH-1:0] rel_addr;
    logic [OW-1:0]         req_offset;
    logic [OW-1:0]         beat_offset;
    logic [OW-1:0]         next_offset;
    logic [4:0]            req_beats;
    logic                  beat_active;
    logic                  beat_rw;

    // In IDLE the first beat is addressed straight from the request so it executes on the accept edge.
    always_comb begin
        rel_addr    = (address - START_ADDR) % DEPTH_B;
        req_offset  = OW'(rel_addr >> 2);
        req_beats   = beats_for_size(access_size);
        beat_active = (state_q == IDLE) ? enable : 1'b1;
        beat_rw     = (state_q == IDLE) ? rw : rw_q;
        beat_offset = (state_q == IDLE) ? req_offset : offset_q;
        next_offset = (beat_offset == LAST_WORD) ? '0 : beat_offset + OW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            offset_q     <= '0;
            rw_q         <= RW_WRITE;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    valid_q <= enable && (rw == RW_READ);
                    if (enable && (req_beats != 5'd1)) begin
                        state_q      <= BURST;
                        beats_left_q <= req_beats - 5'd1;
                        offset_q     <= next_offset;
                        rw_q         <= rw;
                        busy_q       <= 1'b1;
                    end
                end
                BURST: begin
                    valid_q      <= (rw_q == RW_READ);
                    offset_q     <= next_offset;
                    beats_left_q <= beats_left_q - 5'd1;
                    if (beats_left_q == 5'd1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    mem_array #(
        .DATA_WIDTH(DATA_WIDTH),
        .WORDS     (WORDS),
        .AW        (OW)
    ) u_mem_array (
        .clock  (clock),
        .reset_n(reset_n),
        .addr   (beat_offset),
        .we     (beat_active && (beat_rw == RW_WRITE)),
        .wdata  (data_in),
        .re     (beat_active && (beat_rw == RW_READ)),
        .rdata  (data_out)
    );

    assign busy       = busy_q;
    assign data_valid = valid_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// tb/tb_burst_mem_responder.sv - scoreboard bench for burst_mem_responder
module tb_burst_mem_responder;

    localparam int          DEPTH = 1048576;
    localparam int          WORDS = DEPTH / 4;
    localparam logic [31:0] START = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  access_size = '0;
    logic        rw = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [31:0] data_out;
    logic        data_valid;

    int n_pass = 0;
    int n_total = 0;
    int busy_cnt = 0;
    int valid_cnt = 0;

    logic [31:0] model [int unsigned];
    logic [31:0] sb [$];

    burst_mem_responder #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .DEPTH     (DEPTH),
        .START_ADDR(START)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .address    (address),
        .data_in    (data_in),
        .access_size(access_size),
        .rw         (rw),
        .enable     (enable),
        .busy       (busy),
        .data_out   (data_out),
        .data_valid (data_valid)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (reset_n) begin
            if (busy) busy_cnt++;
            if (data_valid) begin
                logic [31:0] exp_d;
                valid_cnt++;
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL rd_unexpected: data_out=%h with no read outstanding", data_out);
                end else begin
                    exp_d = sb.pop_front();
                    if (data_out !== exp_d)
                        $display("FAIL rd_data: got %h expected %h", data_out, exp_d);
                    else
                        n_pass++;
                end
            end
        end
    end

    function automatic int unsigned woff(input logic [31:0] a);
        logic [31:0] r;
        r = (a - START) % 32'(DEPTH);
        return r >> 2;
    endfunction

    function automatic int unsigned nbeats(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return 4;
            2'b10:   return 8;
            default: return 16;
        endcase
    endfunction

    task automatic clr_counts();
        busy_cnt = 0;
        valid_cnt = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        repeat (2) step();
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [1:0] size, input logic rwv,
                          input logic [31:0] d0, input logic [31:0] dstep, input bit disturb);
        int unsigned base;
        int unsigned o;
        int unsigned n;
        base = woff(addr);
        n = nbeats(size);
        for (int k = 0; k < n; k++) begin
            o = (base + k) % WORDS;
            if (k == 0) begin
                enable = 1'b1; address = addr; access_size = size; rw = rwv;
            end else if (disturb && (k == 3 || k == 7)) begin
                enable = 1'b1; address = addr + 32'h400; access_size = 2'b00; rw = ~rwv;
            end else begin
                enable = 1'b0; address = addr; access_size = size; rw = rwv;
            end
            if (rwv == 1'b0) begin
                data_in = d0 + dstep * k;
                model[o] = data_in;
            end else begin
                sb.push_back(model[o]);
            end
            step();
        end
        enable = 1'b0;
    endtask

    task automatic test_reset();
        step();
        n_total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (data_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", data_valid); else n_pass++;
        n_total++; if (data_out !== 32'h0) $display("FAIL rst_data: got %h expected 0", data_out); else n_pass++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        clr_counts();
        do_req(START, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        do_req(START, 2'b00, 1'b1, 32'h0, 32'h0, 1'b0);
        drain();
        n_total++; if (busy_cnt != 0) $display("FAIL single_busy: got %0d cycles expected 0", busy_cnt); else n_pass++;
        n_total++; if (valid_cnt != 1) $display("FAIL single_valid: got %0d cycles expected 1", valid_cnt); else n_pass++;
        n_total++; if (data_out !== 32'hDEAD_BEEF) $display("FAIL single_hold: got %h expected deadbeef", data_out); else n_pass++;
    endtask

    task automatic test_burst4();
        do_req(START + 32'h10, 2'b01, 1'b0, 32'h11, 32'h11, 1'b0);
        drain();
        clr_counts();
        do_req(START + 32'h10, 2'b01, 1'b1, 32'h0, 32'h0, 1'b0);
        drain();
        n_total++; if (busy_cnt != 3) $display("FAIL b4_busy: got %0d cycles expected 3", busy_cnt); else n_pass++;
        n_total++; if (valid_cnt != 4) $display("FAIL b4_valid: got %0d cycles expected 4", valid_cnt); else n_pass++;
        n_total++; if (sb.size() != 0) $display("FAIL b4_sb: got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_burst16_ignore();
        do_req(START + 32'h100, 2'b11, 1'b0, 32'hA000_0000, 32'h1, 1'b0);
        drain();
        clr_counts();
        do_req(START + 32'h100, 2'b11, 1'b1, 32'h0, 32'h0, 1'b1);
        drain();
        n_total++; if (busy_cnt != 15) $display("FAIL b16_busy: got %0d cycles expected 15", busy_cnt); else n_pass++;
        n_total++; if (valid_cnt != 16) $display("FAIL b16_valid: got %0d cycles expected 16", valid_cnt); else n_pass++;
        n_total++; if (sb.size() != 0) $display("FAIL b16_sb: got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        int unsigned base;
        base = woff(START + 32'h100);
        clr_counts();
        enable = 1'b1; address = START + 32'h100; access_size = 2'b10; rw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) sb.push_back(model[base + k]);
            step();
            enable = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        n_total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else n_pass++;
        n_total++; if (data_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", data_valid); else n_pass++;
        n_total++; if (data_out !== 32'h0) $display("FAIL mid_rst_data: got %h expected 0", data_out); else n_pass++;
        n_total++; if (valid_cnt != 3) $display("FAIL mid_rst_beats: got %0d beats expected 3", valid_cnt); else n_pass++;
        step();
        reset_n = 1'b1;
        step();
        clr_counts();
        do_req(START + 32'h100, 2'b10, 1'b1, 32'h0, 32'h0, 1'b0);
        drain();
        n_total++; if (valid_cnt != 8) $display("FAIL post_rst_valid: got %0d expected 8", valid_cnt); else n_pass++;
        n_total++; if (busy_cnt != 7) $display("FAIL post_rst_busy: got %0d expected 7", busy_cnt); else n_pass++;
    endtask

    task automatic test_wrap();
        do_req(START + 32'hC, 2'b00, 1'b0, 32'h3333_3333, 32'h0, 1'b0);
        do_req(START + 32'(DEPTH) - 32'h4, 2'b01, 1'b0, 32'h5000_0001, 32'h1, 1'b0);
        drain();
        n_total++;
        if (model[0] !== 32'h5000_0002) $display("FAIL wrap_model: got %h expected 50000002", model[0]); else n_pass++;
        clr_counts();
        do_req(START, 2'b01, 1'b1, 32'h0, 32'h0, 1'b0);
        do_req(START + 32'(DEPTH) - 32'h4, 2'b01, 1'b1, 32'h0, 32'h0, 1'b0);
        drain();
        n_total++; if (valid_cnt != 8) $display("FAIL wrap_valid: got %0d expected 8", valid_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int unsigned base;
        base = woff(START + 32'h10);
        clr_counts();
        enable = 1'b1; address = START + 32'h10; access_size = 2'b01; rw = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sb.push_back(model[base + k]);
            if (k == 2) begin
                address = START + 32'h200; access_size = 2'b00; rw = 1'b0; data_in = 32'hCAFE_F00D;
            end
            step();
        end
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_fall: got %b expected 0", busy); else n_pass++;
        step();
        enable = 1'b0;
        model[woff(START + 32'h200)] = 32'hCAFE_F00D;
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_busy_w: got %b expected 0", busy); else n_pass++;
        drain();
        n_total++; if (busy_cnt != 3) $display("FAIL b2b_busy_cnt: got %0d expected 3", busy_cnt); else n_pass++;
        n_total++; if (valid_cnt != 4) $display("FAIL b2b_valid: got %0d expected 4", valid_cnt); else n_pass++;
        do_req(START + 32'h200, 2'b00, 1'b1, 32'h0, 32'h0, 1'b0);
        drain();
        n_total++; if (sb.size() != 0) $display("FAIL b2b_sb: got %0d pending expected 0", sb.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_burst16_ignore();
        test_reset_mid_burst();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
